aesl_deadlock_report_ctrl: RTL and testbench

- Sequencer for the per-instance deadlock monitors in the co-simulation bench.
- Watches the `block` outputs and AXI-stream block-info vectors of NUM_MON monitors.
- Declares a deadlock only after blocking has persisted CONFIRM_CYCLES consecutive cycles, then freezes a snapshot.
- Reports each blocked monitor, lowest index first, over a valid/ready handshake to the bench's message/finish logic.

---
 rtl/aesl_deadlock_pkg.sv | 16 +
 rtl/aesl_prio_enc.sv | 25 ++
 rtl/aesl_deadlock_report_ctrl.sv | 106 ++++++++++
 tb/tb_aesl_deadlock_report_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/aesl_deadlock_pkg.sv
// Shared types and constants for the co-simulation deadlock report sequencer.
package aesl_deadlock_pkg;

  localparam int MAX_MON = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CONFIRM,
    SNAPSHOT,
    REPORT,
    DONE
  } state_t;

endpackage

// File: rtl/aesl_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit and
// whether any bit was set at all.
module aesl_prio_enc
  import aesl_deadlock_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scanning from the top down lets the lowest set bit win the last write.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aesl_deadlock_report_ctrl.sv
// Confirms a persistent deadlock across the monitors, freezes a snapshot and
// reports each blocked monitor, lowest index first, over valid/ready.
module aesl_deadlock_report_ctrl
  import aesl_deadlock_pkg::*;
#(
  parameter int NUM_MON        = 4,
  parameter int AXIS_W         = 2,
  parameter int CONFIRM_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_MON-1:0]        mon_block,
  input  logic [NUM_MON*AXIS_W-1:0] mon_axis_info,
  output logic                      report_valid,
  input  logic                      report_ready,
  output logic [IDX_W-1:0]          report_idx,
  output logic [AXIS_W-1:0]         report_axis_info,
  output logic                      deadlock_found,
  output logic                      done
);

  state_t                    state, state_next;
  logic [CNT_W-1:0]          cnt, cnt_next;
  logic [NUM_MON-1:0]        snap_block, snap_block_next;
  logic [NUM_MON*AXIS_W-1:0] snap_info;
  logic                      capture;
  logic                      any_blk;
  logic [IDX_W-1:0]          enc_idx;
  logic                      enc_found;
  logic [NUM_MON-1:0]        remaining;

  assign any_blk   = |mon_block;
  assign remaining = snap_block & ~(NUM_MON'(1) << enc_idx);

  aesl_prio_enc #(.WIDTH(NUM_MON)) u_prio_enc (
    .vec   (snap_block),
    .idx   (enc_idx),
    .found (enc_found)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      snap_block <= '0;
      snap_info  <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      snap_block <= snap_block_next;
      if (capture) snap_info <= mon_axis_info;
    end
  end

  // Enable loss always wins over blocking; one clear cycle restarts the count.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    snap_block_next = snap_block;
    capture         = 1'b0;
    case (state)
      IDLE: if (enable) state_next = ARMED;
      ARMED: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (any_blk) begin
          state_next = CONFIRM;
          cnt_next   = CNT_W'(1);
        end
      end
      CONFIRM: begin
        if (!enable) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (!any_blk) begin
          state_next = ARMED;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(CONFIRM_CYCLES)) begin
          state_next      = SNAPSHOT;
          snap_block_next = mon_block;
          capture         = 1'b1;
        end else if (cnt != '1) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      SNAPSHOT: state_next = enc_found ? REPORT : DONE;
      REPORT: begin
        if (report_ready) begin
          snap_block_next = remaining;
          if (remaining == '0) state_next = DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign report_valid     = (state == REPORT);
  assign report_idx       = report_valid ? enc_idx : '0;
  assign report_axis_info = report_valid ? snap_info[int'(enc_idx)*AXIS_W +: AXIS_W] : '0;
  assign deadlock_found   = (state == SNAPSHOT) || (state == REPORT) || (state == DONE);
  assign done             = (state == DONE);

endmodule

// File: tb/tb_aesl_deadlock_report_ctrl.sv
// Scenario bench: a scoreboard queue of expected report entries is filled
// from each snapshot stimulus and drained as the DUT hands entries over.
module tb_aesl_deadlock_report_ctrl;

  localparam int NUM_MON = 4;
  localparam int AXIS_W  = 2;
  localparam int CONFIRM = 16;

  typedef struct packed {
    logic [3:0]        idx;
    logic [AXIS_W-1:0] info;
  } entry_t;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      enable = 1'b0;
  logic [NUM_MON-1:0]        mon_block = '0;
  logic [NUM_MON*AXIS_W-1:0] mon_axis_info = '0;
  logic                      report_valid;
  logic                      report_ready = 1'b0;
  logic [3:0]                report_idx;
  logic [AXIS_W-1:0]         report_axis_info;
  logic                      deadlock_found;
  logic                      done;

  int     checks = 0;
  int     errors = 0;
  entry_t sb_q[$];

  aesl_deadlock_report_ctrl #(
    .NUM_MON(NUM_MON), .AXIS_W(AXIS_W), .CONFIRM_CYCLES(CONFIRM), .CNT_W(8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .mon_block        (mon_block),
    .mon_axis_info    (mon_axis_info),
    .report_valid     (report_valid),
    .report_ready     (report_ready),
    .report_idx       (report_idx),
    .report_axis_info (report_axis_info),
    .deadlock_found   (deadlock_found),
    .done             (done)
  );

  always #5 clock = ~clock;

  // Outputs are checked and inputs changed on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic push_expected(input logic [NUM_MON-1:0] blk, input logic [NUM_MON*AXIS_W-1:0] info);
    for (int i = 0; i < NUM_MON; i++) begin
      if (blk[i]) sb_q.push_back({4'(i), info[i*AXIS_W +: AXIS_W]});
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; mon_block = '0; mon_axis_info = '0; report_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic wait_deadlock(input string name, input int expected);
    int k = 0;
    while (k < 40) begin
      tick();
      k++;
      if (deadlock_found) break;
    end
    checks++;
    if (k !== expected || report_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: detect after %0d cycles valid=%0b, required %0d cycles valid=0", name, k, report_valid, expected);
    end
  endtask

  task automatic drain(input string name, input int stall_idx, input int stall_cycles, input bit kill_block);
    int stall = stall_cycles;
    entry_t exp_e;
    for (int n = 0; n < 32; n++) begin
      tick();
      if (sb_q.size() == 0) begin
        checks++;
        if (done !== 1'b1 || deadlock_found !== 1'b1 || report_valid !== 1'b0 || report_idx !== 4'd0) begin
          errors++;
          $display("[TB] FAIL %s_done: done=%0b found=%0b valid=%0b idx=%0d, required 1 1 0 0", name, done, deadlock_found, report_valid, report_idx);
        end
        report_ready = 1'b0;
        return;
      end
      exp_e = sb_q[0];
      checks++;
      if (report_valid !== 1'b1 || report_idx !== exp_e.idx || report_axis_info !== exp_e.info) begin
        errors++;
        $display("[TB] FAIL %s_entry: valid=%0b idx=%0d info=%b, required 1 %0d %b", name, report_valid, report_idx, report_axis_info, exp_e.idx, exp_e.info);
      end
      if (kill_block) mon_block = '0;
      if (int'(exp_e.idx) == stall_idx && stall > 0) begin
        report_ready = 1'b0;
        stall--;
      end else begin
        report_ready = 1'b1;
        void'(sb_q.pop_front());
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s_timeout: %0d entries left, required 0", name, sb_q.size());
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({report_valid, report_idx, report_axis_info, deadlock_found, done} !== '0) begin
      errors++;
      $display("[TB] FAIL reset: outputs=%b, required all 0", {report_valid, report_idx, report_axis_info, deadlock_found, done});
    end
  endtask

  task automatic test_no_block();
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (deadlock_found !== 1'b0 || report_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL no_block: found=%0b valid=%0b done=%0b, required 0 0 0", deadlock_found, report_valid, done);
      end
    end
  endtask

  task automatic test_confirm_restart();
    mon_axis_info = 8'b00_10_00_00;
    mon_block = 4'b0100;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) mon_block = 4'b0000;
      tick();
      checks++;
      if (deadlock_found !== 1'b0) begin
        errors++;
        $display("[TB] FAIL first_burst: found=%0b at cycle %0d, required 0", deadlock_found, i);
      end
    end
    mon_block = 4'b0100;
    push_expected(mon_block, mon_axis_info);
    wait_deadlock("second_burst", CONFIRM + 1);
    drain("single", -1, 0, 1'b0);
  endtask

  task automatic reach_snapshot(input string name, input logic [NUM_MON-1:0] blk, input logic [NUM_MON*AXIS_W-1:0] info);
    apply_reset();
    enable = 1'b1;
    tick();
    mon_block = blk;
    mon_axis_info = info;
    push_expected(blk, info);
    wait_deadlock(name, CONFIRM + 1);
  endtask

  task automatic test_back_to_back();
    reach_snapshot("b2b_detect", 4'b1011, 8'b01_00_10_11);
    drain("b2b", -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    reach_snapshot("stall_detect", 4'b1011, 8'b01_00_10_11);
    drain("stall", 1, 5, 1'b1);
    enable = 1'b0;
    mon_block = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b1 || deadlock_found !== 1'b1 || report_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL done_sticky: done=%0b found=%0b valid=%0b, required 1 1 0", done, deadlock_found, report_valid);
      end
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    enable = 1'b1;
    tick();
    mon_block = 4'b0010;
    mon_axis_info = 8'b00_00_01_00;
    for (int i = 0; i < 8; i++) tick();
    enable = 1'b0;
    tick();
    checks++;
    if (deadlock_found !== 1'b0) begin
      errors++;
      $display("[TB] FAIL enable_drop: found=%0b, required 0", deadlock_found);
    end
    enable = 1'b1;
    tick();
    push_expected(mon_block, mon_axis_info);
    wait_deadlock("reconfirm", CONFIRM + 1);
    drain("reenable", -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_report();
    reach_snapshot("mid_detect", 4'b1011, 8'b01_00_10_11);
    tick();
    report_ready = 1'b1;
    tick();
    report_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    checks++;
    if ({report_valid, report_idx, report_axis_info, deadlock_found, done} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset: outputs=%b, required all 0", {report_valid, report_idx, report_axis_info, deadlock_found, done});
    end
    push_expected(mon_block, mon_axis_info);
    wait_deadlock("after_reset", CONFIRM + 2);
    drain("after_reset", -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_no_block();
    test_confirm_restart();
    test_back_to_back();
    test_stall();
    test_enable_drop();
    test_reset_mid_report();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
